// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Subtract mode is compiled in with SERIAL_ADDER_SUB_EN (see serial_adder_ctrl).
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Purely combinational 1-bit full adder cell, time-shared by serial_adder_ctrl.
module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder cell, operands shifted LSB-first.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port (a - b via ~b and carry-in 1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output state_t           state_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fa_s, fa_c;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub_i ? ~b_i : b_i;
    assign carry_load = sub_i ? 1'b1 : cin_i;
`else
    assign b_load     = b_i;
    assign carry_load = cin_i;
`endif

    fa_bit u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_s),
        .cout_o (fa_c)
    );

    // New bit enters at the MSB so the LSB-first stream lands in order.
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_shift;
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 instance plus a WIDTH=1 instance.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // WIDTH=8 instance
    logic       start, cin, sub;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;
    state_t     state;

    // WIDTH=1 instance
    logic       s_start, s_cin, s_sub;
    logic [0:0] s_a, s_b;
    logic       s_busy, s_done, s_cout;
    logic [0:0] s_sum;
    state_t     s_state;

    serial_adder_ctrl #(.WIDTH(8)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout),
        .state_o (state)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (s_start),
        .a_i     (s_a),
        .b_i     (s_b),
        .cin_i   (s_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (s_sub),
`endif
        .busy_o  (s_busy),
        .done_o  (s_done),
        .sum_o   (s_sum),
        .cout_o  (s_cout),
        .state_o (s_state)
    );

    // scoreboard
    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // driver: one operation on the WIDTH=8 instance, optional start poke mid-RUN
    task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vcin, input logic vsub, input logic [8:0] exp,
                         input bit poke);
        int lat;
        int busy_cnt;
        logic [8:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            start = (poke && lat == 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_eq({tag, ".latency"}, 64'(lat), 64'd8);
        check_eq({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd8);
        check_eq({tag, ".done"}, 64'(done), 64'd1);
        e = exp_q.pop_front();
        check_eq({tag, ".cout_sum"}, 64'({cout, sum}), 64'(e));
        @(negedge clk);
        check_eq({tag, ".done_pulse_end"}, 64'(done), 64'd0);
        check_eq({tag, ".back_to_idle"}, 64'(state), 64'(IDLE));
    endtask

    initial begin
        int lat;
        int n;
        int done_seen;
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle.busy", 64'(busy), 64'd0);
            check_eq("idle.done", 64'(done), 64'd0);
            check_eq("idle.sum", 64'(sum), 64'h00);
            check_eq("idle.cout", 64'(cout), 64'd0);
        end
        check_eq("idle.state", 64'(state), 64'(IDLE));

        // basic add, carry/wrap with ignored mid-RUN start
        do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 8'h10}, 1'b0);
        do_op("wrap_ff_01_c1", 8'hFF, 8'h01, 1'b1, 1'b0, {1'b1, 8'h01}, 1'b1);
        do_op("add_aa_55_c1", 8'hAA, 8'h55, 1'b1, 1'b0, {1'b1, 8'h00}, 1'b0);
        do_op("add_3c_c3", 8'h3C, 8'hC3, 1'b0, 1'b0, {1'b0, 8'hFF}, 1'b0);

        // back-to-back: start held, new operands presented during DONE
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h80; b = 8'h80;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b2b.first_latency", 64'(lat), 64'd8);
        check_eq("b2b.first_result", 64'({cout, sum}), 64'({1'b0, 8'h46}));
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b.no_idle_gap", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b.done_spacing", 64'(n), 64'd9);
        check_eq("b2b.second_result", 64'({cout, sum}), 64'({1'b1, 8'h00}));
        @(negedge clk);
        check_eq("b2b.idle_after", 64'(state), 64'(IDLE));

        // reset mid-operation
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_mid.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid.busy", 64'(busy), 64'd0);
        check_eq("rst_mid.done", 64'(done), 64'd0);
        check_eq("rst_mid.sum", 64'(sum), 64'h00);
        check_eq("rst_mid.cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_eq("rst_mid.no_done", 64'(done_seen), 64'd0);
        do_op("after_rst_03_04", 8'h03, 8'h04, 1'b0, 1'b0, {1'b0, 8'h07}, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 8'hFE}, 1'b0);
        do_op("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, {1'b1, 8'h02}, 1'b0);
`endif

        // WIDTH=1 instance
        @(negedge clk);
        s_a = 1'b1; s_b = 1'b1; s_cin = 1'b1; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check_eq("w1.busy", 64'(s_busy), 64'd1);
        lat = 0;
        while (!s_done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("w1.latency", 64'(lat), 64'd1);
        check_eq("w1.result_111", 64'({s_cout, s_sum}), 64'(2'b11));
        @(negedge clk);
        s_a = 1'b1; s_b = 1'b0; s_cin = 1'b0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        lat = 0;
        while (!s_done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("w1.latency2", 64'(lat), 64'd1);
        check_eq("w1.result_100", 64'({s_cout, s_sum}), 64'(2'b01));

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
